// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared state encoding and peripheral address map for the I/O bus
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } bus_state_t;

    // Address parked on the bus between transactions; decodes to no peripheral.
    localparam logic [7:0] IDLE_ADDR_DEFAULT = 8'hFF;

    localparam logic [7:0] SWITCHES_BASE = 8'hE0;
    localparam logic [7:0] LEDS_BASE     = 8'hC0;
    localparam logic [7:0] TIMER_BASE    = 8'hF0;

    localparam int MAX_REQ = 4;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick, searching cyclically from last+1
module rr_priority_select #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic [N-1:0] winner,
    output logic [1:0]   winner_idx,
    output logic         any
);

    // Loops unroll to constant indices; the first hit in search order wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && ((int'(last) + k) % N == i)) begin
                    any        = 1'b1;
                    winner[i]  = 1'b1;
                    winner_idx = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin arbiter and sequencer for the shared 8-bit peripheral bus
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter int         READ_LAT  = 2,
    parameter logic [7:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [8*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [8*NUM_REQ-1:0]   REQ_WDATA,
    input  logic [NUM_REQ-1:0]     REQ_WE,
    output logic [NUM_REQ-1:0]     GNT,
    output logic [NUM_REQ-1:0]     DONE,
    output logic [7:0]             RDATA,
    output logic                   BUSY,
    output logic [7:0]             BUS_ADDR,
    inout  wire  [7:0]             BUS_DATA,
    output logic                   BUS_WE
);

    bus_state_t           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [1:0]           last_q, last_d;
    logic [7:0]           rdata_q, rdata_d;

    logic [NUM_REQ-1:0]   sel_oh;
    logic [1:0]           sel_idx;
    logic                 sel_any;

    logic [NUM_REQ-1:0]   gnt_d, done_d;
    logic [7:0]           bus_addr_d;
    logic                 bus_we_d, busy_d;

    rr_priority_select #(.N(NUM_REQ)) u_select (
        .req        (REQ),
        .last       (last_q),
        .winner     (sel_oh),
        .winner_idx (sel_idx),
        .any        (sel_any)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= IDLE_ADDR;
            wdata_q <= '0;
            owner_q <= '0;
            last_q  <= 2'(NUM_REQ - 1);
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel_oh[i]) begin
                            addr_d  = REQ_ADDR[8*i +: 8];
                            wdata_d = REQ_WDATA[8*i +: 8];
                        end
                    end
                    owner_d = sel_oh;
                    last_d  = sel_idx;
                    if (|(REQ_WE & sel_oh)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = 3'd1;
                    end
                end
            end
            ST_WRITE: state_d = ST_TURN;
            ST_READ: begin
                // Peripheral data appears the cycle after the address; sample on the last held cycle.
                if (cnt_q == 3'(READ_LAT)) begin
                    rdata_d = BUS_DATA;
                    state_d = ST_TURN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they land in registers aligned with it.
    always_comb begin
        gnt_d      = '0;
        done_d     = '0;
        bus_addr_d = IDLE_ADDR;
        bus_we_d   = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_READ: begin
                bus_addr_d = addr_d;
                if (state_q == ST_IDLE) gnt_d = owner_d;
            end
            ST_WRITE: begin
                bus_addr_d = addr_d;
                bus_we_d   = 1'b1;
                gnt_d      = owner_d;
            end
            ST_TURN: done_d = owner_d;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            GNT      <= '0;
            DONE     <= '0;
            BUSY     <= 1'b0;
            BUS_ADDR <= IDLE_ADDR;
            BUS_WE   <= 1'b0;
        end else begin
            GNT      <= gnt_d;
            DONE     <= done_d;
            BUSY     <= busy_d;
            BUS_ADDR <= bus_addr_d;
            BUS_WE   <= bus_we_d;
        end
    end

    assign RDATA    = rdata_q;
    assign BUS_DATA = (state_q == ST_WRITE) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - scoreboard bench for io_bus_arbiter at READ_LAT 2 and 3
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    typedef struct {
        int         idx;
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req [2];
    logic [15:0] req_addr [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_we [2];
    logic [1:0]  gnt [2];
    logic [1:0]  done [2];
    logic [7:0]  rdata [2];
    logic        busy [2];
    logic [7:0]  bus_addr [2];
    logic        bus_we [2];
    wire  [7:0]  bus_data_a;
    wire  [7:0]  bus_data_b;

    logic        per_en [2];
    logic [7:0]  per_q [2];
    logic [7:0]  led [2] = '{8'h00, 8'h00};

    txn_t exp_q [2][$];
    bit   in_txn [2];
    int   gnt_cyc [2];
    int   rd_hold [2];
    int   we_cnt [2];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    io_bus_arbiter #(.NUM_REQ(2), .READ_LAT(2)) dut_a (
        .CLK(clk), .RESET(rst_n), .REQ(req[0]), .REQ_ADDR(req_addr[0]),
        .REQ_WDATA(req_wdata[0]), .REQ_WE(req_we[0]), .GNT(gnt[0]), .DONE(done[0]),
        .RDATA(rdata[0]), .BUSY(busy[0]), .BUS_ADDR(bus_addr[0]),
        .BUS_DATA(bus_data_a), .BUS_WE(bus_we[0])
    );

    io_bus_arbiter #(.NUM_REQ(2), .READ_LAT(3)) dut_b (
        .CLK(clk), .RESET(rst_n), .REQ(req[1]), .REQ_ADDR(req_addr[1]),
        .REQ_WDATA(req_wdata[1]), .REQ_WE(req_we[1]), .GNT(gnt[1]), .DONE(done[1]),
        .RDATA(rdata[1]), .BUSY(busy[1]), .BUS_ADDR(bus_addr[1]),
        .BUS_DATA(bus_data_b), .BUS_WE(bus_we[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Switch peripheral with registered output: SWL=5A at E0, SWH=C3 at E1.
    assign bus_data_a = per_en[0] ? per_q[0] : 8'hzz;
    assign bus_data_b = per_en[1] ? per_q[1] : 8'hzz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_en[0] <= 1'b0;
            per_en[1] <= 1'b0;
            per_q[0]  <= 8'h00;
            per_q[1]  <= 8'h00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                per_en[k] <= !bus_we[k] && (bus_addr[k] == SWITCHES_BASE ||
                                            bus_addr[k] == SWITCHES_BASE + 8'd1);
                per_q[k]  <= (bus_addr[k] == SWITCHES_BASE) ? 8'h5A : 8'hC3;
            end
        end
    end

    always @(posedge clk) begin
        if (bus_we[0] && bus_addr[0] == LEDS_BASE) led[0] <= bus_data_a;
        if (bus_we[1] && bus_addr[1] == LEDS_BASE) led[1] <= bus_data_b;
    end

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        txn_t h;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                in_txn[k] = 1'b0;
                continue;
            end
            if (gnt[k] != 2'b00) begin
                if (exp_q[k].size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt[k]), 32'd0);
                end else begin
                    h = exp_q[k][0];
                    chk("gnt_order", 32'(gnt[k]), 32'd1 << h.idx);
                    chk("gnt_while_busy", 32'(in_txn[k]), 32'd0);
                    in_txn[k]  = 1'b1;
                    gnt_cyc[k] = cyc;
                    rd_hold[k] = 0;
                    we_cnt[k]  = 0;
                end
            end
            if (in_txn[k] && busy[k] && !bus_we[k] && bus_addr[k] != 8'hFF) rd_hold[k]++;
            if (bus_we[k]) begin
                we_cnt[k]++;
                chk("no_contention", 32'(per_en[k]), 32'd0);
                if (exp_q[k].size() != 0) begin
                    chk("wr_addr", 32'(bus_addr[k]), 32'(exp_q[k][0].addr));
                    chk("wr_data", 32'((k == 0) ? bus_data_a : bus_data_b), 32'(exp_q[k][0].data));
                end
            end
            if (done[k] != 2'b00) begin
                if (exp_q[k].size() == 0) begin
                    chk("done_unexpected", 32'(done[k]), 32'd0);
                end else begin
                    h = exp_q[k].pop_front();
                    chk("done_owner", 32'(done[k]), 32'd1 << h.idx);
                    chk("done_latency", 32'(cyc - gnt_cyc[k]), h.we ? 32'd1 : 32'(lat(k)));
                    if (h.we) begin
                        chk("write_cycles", 32'(we_cnt[k]), 32'd1);
                    end else begin
                        chk("rdata", 32'(rdata[k]), 32'(h.data));
                        chk("read_hold", 32'(rd_hold[k]), 32'(lat(k)));
                    end
                    in_txn[k] = 1'b0;
                end
            end
        end
    end

    task automatic queue_txn(input int k, input int i, input bit we,
                             input logic [7:0] addr, input logic [7:0] data);
        txn_t t;
        req_addr[k][8*i +: 8]  = addr;
        req_wdata[k][8*i +: 8] = data;
        req_we[k][i]           = we;
        t.idx  = i;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        exp_q[k].push_back(t);
    endtask

    task automatic wait_idle(input int k);
        int t;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy[k] && exp_q[k].size() == 0) break;
        end
        chk("idle_timeout", 32'(t >= 50), 32'd0);
    endtask

    // Holds REQ bits until each requester has collected its number of grants.
    task automatic run_reqs(input int k, input int n0, input int n1);
        int left [2];
        left[0] = n0;
        left[1] = n1;
        req[k]  = req[k] | {1'(n1 > 0), 1'(n0 > 0)};
        for (int t = 0; t < 400 && (left[0] > 0 || left[1] > 0); t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (gnt[k][i] && left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) req[k][i] = 1'b0;
                end
            end
        end
        chk("grant_timeout", 32'(left[0] + left[1]), 32'd0);
        req[k] = 2'b00;
        wait_idle(k);
    endtask

    task automatic chk_idle_outputs(input int k, input logic [7:0] exp_rdata);
        chk("rst_bus_addr", 32'(bus_addr[k]), 32'hFF);
        chk("rst_bus_we",   32'(bus_we[k]),   32'd0);
        chk("rst_busy",     32'(busy[k]),     32'd0);
        chk("rst_gnt",      32'(gnt[k]),      32'd0);
        chk("rst_done",     32'(done[k]),     32'd0);
        chk("rst_rdata",    32'(rdata[k]),    32'(exp_rdata));
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k]       = 2'b00;
            req_addr[k]  = 16'h0000;
            req_wdata[k] = 16'h0000;
            req_we[k]    = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs(0, 8'h00);
        chk_idle_outputs(1, 8'h00);

        // Both requesters held from reset: strict alternation 0,1,0,1.
        queue_txn(0, 0, 1'b0, 8'hE0, 8'h5A);
        queue_txn(0, 1, 1'b1, 8'hC0, 8'h77);
        queue_txn(0, 0, 1'b0, 8'hE0, 8'h5A);
        queue_txn(0, 1, 1'b1, 8'hC0, 8'h77);
        req[0] = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        run_reqs(0, 2, 2);
        chk("led_after_77", 32'(led[0]), 32'h77);

        queue_txn(0, 0, 1'b0, 8'hE0, 8'h5A);
        run_reqs(0, 1, 0);
        queue_txn(0, 0, 1'b0, 8'hE1, 8'hC3);
        run_reqs(0, 1, 0);
        queue_txn(0, 1, 1'b1, 8'hC0, 8'h3C);
        run_reqs(0, 0, 1);
        chk("led_after_3c", 32'(led[0]), 32'h3C);

        // Single requester back-to-back.
        queue_txn(0, 1, 1'b0, 8'hE1, 8'hC3);
        queue_txn(0, 1, 1'b0, 8'hE1, 8'hC3);
        queue_txn(0, 1, 1'b0, 8'hE1, 8'hC3);
        run_reqs(0, 0, 3);

        // Reset during the second READ cycle aborts; held REQ[0] is re-granted afterwards.
        queue_txn(0, 0, 1'b0, 8'hE0, 8'h5A);
        queue_txn(0, 0, 1'b0, 8'hE0, 8'h5A);
        req[0][0] = 1'b1;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (gnt[0][0]) break;
        end
        chk("abort_gnt_seen", 32'(t < 20), 32'd1);
        @(posedge clk);
        #1;
        chk("abort_addr_before", 32'(bus_addr[0]), 32'hE0);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs(0, 8'h00);
        void'(exp_q[0].pop_front());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_reqs(0, 1, 0);

        // READ_LAT=3 instance.
        queue_txn(1, 0, 1'b0, 8'hE0, 8'h5A);
        run_reqs(1, 1, 0);
        queue_txn(1, 0, 1'b0, 8'hE1, 8'hC3);
        run_reqs(1, 1, 0);
        queue_txn(1, 0, 1'b1, 8'hC0, 8'h99);
        run_reqs(1, 1, 0);
        chk("led_b_after_99", 32'(led[1]), 32'h99);

        repeat (3) @(negedge clk);
        chk("queue_a_drained", 32'(exp_q[0].size()), 32'd0);
        chk("queue_b_drained", 32'(exp_q[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
